// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: width codes, FSM states and request legality shared by the load/store unit
package load_store_unit_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } width_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1,
        RESP
    } state_e;

    // Unsigned widths only make sense for loads
    function automatic logic width_legal(input logic [2:0] w, input logic wr);
        return (w == LB) || (w == LH) || (w == LW) || (!wr && ((w == LBU) || (w == LHU)));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane rotation and load extraction/extension for one access
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_width,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata0,
    input  logic [31:0] i_rdata1,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic        o_split,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [3:0]  w_mask;
    logic [7:0]  w_be;
    logic [4:0]  w_sh;
    logic [31:0] w_rlo;
    logic        w_sx;

    always_comb begin
        w_mask  = (i_width[1:0] == 2'b00) ? 4'b0001 : (i_width[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
        w_be    = {4'b0000, w_mask} << i_off;
        w_sh    = {i_off, 3'b000};
        o_be0   = w_be[3:0];
        o_be1   = w_be[7:4];
        o_split = |w_be[7:4];
        o_wdata = (i_wdata << w_sh) | (i_wdata >> (6'd32 - {1'b0, w_sh}));
        w_rlo   = 32'({i_rdata1, i_rdata0} >> w_sh);
        w_sx    = (i_width == LB) || (i_width == LH);
        o_rdata = (i_width[1:0] == 2'b00) ? {{24{w_sx & w_rlo[7]}}, w_rlo[7:0]} :
                  (i_width[1:0] == 2'b01) ? {{16{w_sx & w_rlo[15]}}, w_rlo[15:0]} : w_rlo;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine splitting misaligned accesses into two bus beats
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Mem_Wr,
    input  logic [2:0]  dWidth_ctrl,
    input  logic [31:0] Addr,
    input  logic [31:0] Wr_Data,
    output logic        Rsp_Valid,
    output logic [31:0] Rd_Data,
    output logic        Rsp_Err,
    output logic        Bus_Req,
    output logic        Bus_We,
    output logic [31:0] Bus_Addr,
    output logic [31:0] Bus_WData,
    output logic [3:0]  Bus_BE,
    input  logic        Bus_Gnt,
    input  logic        Bus_RValid,
    input  logic [31:0] Bus_RData
);
    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYC);

    state_e        r_state;
    state_e        w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_beat0;
    logic [31:0]   r_rd_data;
    logic [2:0]    r_width;
    logic          r_wr;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic [3:0]    w_be0;
    logic [3:0]    w_be1;
    logic          w_split;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ld;
    logic [31:0]   w_rd0;
    logic          w_ack;
    logic          w_expire;

    lsu_align u_align (
        .i_off    (r_addr[1:0]),
        .i_width  (r_width),
        .i_wdata  (r_wdata),
        .i_rdata0 (w_rd0),
        .i_rdata1 (Bus_RData),
        .o_be0    (w_be0),
        .o_be1    (w_be1),
        .o_split  (w_split),
        .o_wdata  (w_wdata),
        .o_rdata  (w_ld)
    );

    assign Req_Ready = (r_state == IDLE);
    assign Rsp_Valid = (r_state == RESP);
    assign Rsp_Err   = Rsp_Valid & r_err;
    assign Rd_Data   = r_rd_data;
    assign Bus_Req   = (r_state == REQ0) || (r_state == REQ1);
    assign Bus_We    = Bus_Req & r_wr;
    assign Bus_Addr  = {r_addr[31:2], 2'b00} + ((r_state == REQ1) ? 32'd4 : 32'd0);
    assign Bus_WData = w_wdata;
    assign Bus_BE    = !Bus_Req ? 4'b0000 : (r_state == REQ1) ? w_be1 : w_be0;
    // Beat 0 arrives live in WAIT0 and is replayed from its register for the second beat
    assign w_rd0     = (r_state == WAIT0) ? Bus_RData : r_beat0;
    assign w_ack     = Bus_Req ? Bus_Gnt : Bus_RValid;
    assign w_expire  = (r_cnt <= CW'(1));

    always_comb begin
        w_next = (r_state == REQ0)  ? (!r_wr ? WAIT0 : w_split ? REQ1 : RESP) :
                 (r_state == WAIT0) ? (w_split ? REQ1 : RESP) :
                 (r_state == REQ1)  ? (!r_wr ? WAIT1 : RESP) : RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_beat0   <= '0;
            r_rd_data <= '0;
            r_width   <= '0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else if (r_state == IDLE) begin
            if (Req_Valid) begin
                r_addr  <= Addr;
                r_wdata <= Wr_Data;
                r_wr    <= Mem_Wr;
                r_width <= dWidth_ctrl;
                if (width_legal(dWidth_ctrl, Mem_Wr)) begin
                    r_state <= REQ0;
                    r_cnt   <= TO_LOAD;
                end else begin
                    r_state   <= RESP;
                    r_err     <= 1'b1;
                    r_rd_data <= '0;
                end
            end
        end else if (r_state == RESP) begin
            r_state <= IDLE;
        end else if (!w_ack) begin
            if (w_expire) begin
                r_state   <= RESP;
                r_err     <= 1'b1;
                r_rd_data <= '0;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else begin
            r_state <= w_next;
            r_cnt   <= TO_LOAD;
            if (r_state == WAIT0) r_beat0 <= Bus_RData;
            if (w_next == RESP) begin
                r_err     <= 1'b0;
                r_rd_data <= r_wr ? '0 : w_ld;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store, split, extension, error, timeout and reset checks
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Mem_Wr;
    logic [2:0]  dWidth_ctrl;
    logic [31:0] Addr;
    logic [31:0] Wr_Data;
    logic        Rsp_Valid;
    logic [31:0] Rd_Data;
    logic        Rsp_Err;
    logic        Bus_Req;
    logic        Bus_We;
    logic [31:0] Bus_Addr;
    logic [31:0] Bus_WData;
    logic [3:0]  Bus_BE;
    logic        Bus_Gnt;
    logic        Bus_RValid;
    logic [31:0] Bus_RData;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;
    int          nreq;

    load_store_unit #(.TIMEOUT_CYC(255)) dut (
        .clk(clk), .rst_n(rst_n), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready),
        .Mem_Wr(Mem_Wr), .dWidth_ctrl(dWidth_ctrl), .Addr(Addr), .Wr_Data(Wr_Data),
        .Rsp_Valid(Rsp_Valid), .Rd_Data(Rd_Data), .Rsp_Err(Rsp_Err),
        .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_WData(Bus_WData),
        .Bus_BE(Bus_BE), .Bus_Gnt(Bus_Gnt), .Bus_RValid(Bus_RValid), .Bus_RData(Bus_RData)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        Req_Valid = 1'b1; Mem_Wr = wr; dWidth_ctrl = w; Addr = a; Wr_Data = d;
        tick;
        Req_Valid = 1'b0; Mem_Wr = ~wr; dWidth_ctrl = 3'b111; Addr = ~a; Wr_Data = ~d;
    endtask

    task automatic do_store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] ew, input logic two, input logic [3:0] b0,
                            input logic [3:0] b1, input int hold);
        logic [31:0] a0;
        a0 = {a[31:2], 2'b00};
        issue(1'b1, w, a, d);
        for (int i = 0; i <= hold; i++) begin
            chk("st_req0", {Bus_Req, Bus_We, Bus_BE}, {2'b11, b0});
            chk("st_addr0", Bus_Addr, a0);
            chk("st_wdata0", Bus_WData, ew);
            if (i < hold) tick;
        end
        Bus_Gnt = 1'b1; tick; Bus_Gnt = 1'b0;
        if (two) begin
            chk("st_req1", {Bus_Req, Bus_We, Bus_BE}, {2'b11, b1});
            chk("st_addr1", Bus_Addr, a0 + 32'd4);
            chk("st_wdata1", Bus_WData, ew);
            Bus_Gnt = 1'b1; tick; Bus_Gnt = 1'b0;
        end
        chk("st_rsp", {Rsp_Valid, Rsp_Err, Bus_Req}, 3'b100);
        chk("st_rdata", Rd_Data, 32'h0);
        tick;
        chk("st_idle", {Req_Ready, Rsp_Valid}, 2'b10);
    endtask

    task automatic do_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] r0,
                           input logic [31:0] r1, input logic two, input logic [3:0] b0,
                           input logic [3:0] b1, input logic [31:0] exp);
        logic [31:0] a0;
        a0 = {a[31:2], 2'b00};
        issue(1'b0, w, a, 32'h5A5A5A5A);
        chk("ld_req0", {Bus_Req, Bus_We, Bus_BE}, {2'b10, b0});
        chk("ld_addr0", Bus_Addr, a0);
        Bus_Gnt = 1'b1; Bus_RValid = 1'b1; Bus_RData = 32'hDEADBEEF;
        tick;
        Bus_Gnt = 1'b0; Bus_RValid = 1'b0;
        chk("ld_wait0", {Bus_Req, Rsp_Valid, Req_Ready}, 3'b000);
        Bus_RValid = 1'b1; Bus_RData = r0; tick; Bus_RValid = 1'b0;
        if (two) begin
            chk("ld_req1", {Bus_Req, Bus_We, Bus_BE}, {2'b10, b1});
            chk("ld_addr1", Bus_Addr, a0 + 32'd4);
            Bus_Gnt = 1'b1; tick; Bus_Gnt = 1'b0;
            chk("ld_wait1", {Bus_Req, Rsp_Valid}, 2'b00);
            Bus_RValid = 1'b1; Bus_RData = r1; tick; Bus_RValid = 1'b0;
        end
        chk("ld_rsp", {Rsp_Valid, Rsp_Err}, 2'b10);
        chk("ld_data", Rd_Data, exp);
        tick;
        chk("ld_idle", {Req_Ready, Rsp_Valid}, 2'b10);
        chk("ld_hold", Rd_Data, exp);
    endtask

    initial begin
        rst_n = 1'b0; Req_Valid = 1'b0; Mem_Wr = 1'b0; dWidth_ctrl = 3'b000; Addr = 32'h0;
        Wr_Data = 32'h0; Bus_Gnt = 1'b0; Bus_RValid = 1'b0; Bus_RData = 32'h0;
        tick; tick;
        chk("rst_ready", {31'h0, Req_Ready}, 32'h1);
        chk("rst_rsp", {Rsp_Valid, Rsp_Err}, 2'b00);
        chk("rst_rd", Rd_Data, 32'h0);
        chk("rst_bus", {Bus_Req, Bus_We, Bus_BE}, 6'h00);
        chk("rst_addr", Bus_Addr, 32'h0);
        chk("rst_wdata", Bus_WData, 32'h0);
        rst_n = 1'b1; tick;
        Bus_Gnt = 1'b1; Bus_RValid = 1'b1; tick; tick;
        chk("idle_stray", {Req_Ready, Rsp_Valid, Bus_Req}, 3'b100);
        Bus_Gnt = 1'b0; Bus_RValid = 1'b0;

        do_store(3'b000, 32'h00001003, 32'h000000AB, 32'hAB000000, 1'b0, 4'b1000, 4'b0000, 0);
        do_store(3'b001, 32'h00006001, 32'h0000BEEF, 32'h00BEEF00, 1'b0, 4'b0110, 4'b0000, 2);
        do_store(3'b001, 32'h00007003, 32'h00001234, 32'h34000012, 1'b1, 4'b1000, 4'b0001, 0);
        do_store(3'b010, 32'hFFFFFFFE, 32'h11223344, 32'h33441122, 1'b1, 4'b1100, 4'b0011, 1);

        do_load(3'b001, 32'h00002003, 32'h80123456, 32'hABCDEF01, 1'b1, 4'b1000, 4'b0001, 32'h00000180);
        do_load(3'b101, 32'h00002003, 32'h80123456, 32'hABCDEF01, 1'b1, 4'b1000, 4'b0001, 32'h00000180);
        do_load(3'b001, 32'h00002003, 32'h80123456, 32'hABCDEF81, 1'b1, 4'b1000, 4'b0001, 32'hFFFF8180);
        do_load(3'b000, 32'h00003000, 32'h12345680, 32'h0, 1'b0, 4'b0001, 4'b0000, 32'hFFFFFF80);
        do_load(3'b100, 32'h00003000, 32'h12345680, 32'h0, 1'b0, 4'b0001, 4'b0000, 32'h00000080);
        do_load(3'b010, 32'h00004000, 32'h12345678, 32'h0, 1'b0, 4'b1111, 4'b0000, 32'h12345678);
        do_load(3'b010, 32'h00004001, 32'h11223344, 32'h55667788, 1'b1, 4'b1110, 4'b0001, 32'h88112233);
        do_load(3'b001, 32'h00005002, 32'h7FFE1234, 32'h0, 1'b0, 4'b1100, 4'b0000, 32'h00007FFE);
        do_store(3'b000, 32'h00008002, 32'h000000C3, 32'h00C30000, 1'b0, 4'b0100, 4'b0000, 0);

        issue(1'b0, 3'b011, 32'h00009000, 32'h0);
        chk("ill_011", {Rsp_Valid, Rsp_Err, Bus_Req}, 3'b110);
        tick;
        chk("ill_011_idle", {Req_Ready, Rsp_Valid, Bus_Req}, 3'b100);
        issue(1'b1, 3'b100, 32'h00009000, 32'h0);
        chk("ill_st_bu", {Rsp_Valid, Rsp_Err, Bus_Req}, 3'b110);
        tick;
        issue(1'b0, 3'b110, 32'h00009000, 32'h0);
        chk("ill_110", {Rsp_Valid, Rsp_Err, Bus_Req}, 3'b110);
        tick;

        issue(1'b0, 3'b010, 32'h00005000, 32'h0);
        n = 0; nreq = 0;
        while (!Rsp_Valid && n < 400) begin
            if (Bus_Req) nreq++;
            tick;
            n++;
        end
        chk("tmo_gnt_cycles", n, 32'd255);
        chk("tmo_gnt_req_cycles", nreq, 32'd255);
        chk("tmo_gnt_rsp", {Rsp_Valid, Rsp_Err, Bus_Req}, 3'b110);
        tick;
        chk("tmo_gnt_idle", {Req_Ready, Rsp_Valid}, 2'b10);

        issue(1'b0, 3'b010, 32'h00005000, 32'h0);
        Bus_Gnt = 1'b1; tick; Bus_Gnt = 1'b0;
        n = 0;
        while (!Rsp_Valid && n < 400) begin
            tick;
            n++;
        end
        chk("tmo_rv_cycles", n, 32'd255);
        chk("tmo_rv_rsp", {Rsp_Valid, Rsp_Err, Bus_Req}, 3'b110);
        tick;

        do_load(3'b000, 32'h0000A001, 32'h0000FF00, 32'h0, 1'b0, 4'b0010, 4'b0000, 32'hFFFFFFFF);
        issue(1'b0, 3'b010, 32'h0000A000, 32'h0);
        Bus_Gnt = 1'b1; tick; Bus_Gnt = 1'b0;
        chk("pre_rst_wait0", {Bus_Req, Req_Ready, Rsp_Valid}, 3'b000);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async", {Req_Ready, Rsp_Valid, Bus_Req}, 3'b100);
        chk("rst_async_rd", Rd_Data, 32'h0);
        tick;
        rst_n = 1'b1;
        Bus_RValid = 1'b1; Bus_RData = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_stray_rv", {Req_Ready, Rsp_Valid, Bus_Req}, 3'b100);
        end
        Bus_RValid = 1'b0;
        chk("rst_stray_rd", Rd_Data, 32'h0);
        do_load(3'b101, 32'h0000B002, 32'h9ABC0000, 32'h0, 1'b0, 4'b1100, 4'b0000, 32'h00009ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles waited for any single bus grant or read return before aborting.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- Req_Valid  in  1  core presents a memory operation.
- Req_Ready  out  1  unit idle and accepting.
- Mem_Wr  in  1  1 = store, 0 = load.
- dWidth_ctrl  in  3  funct3 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Addr  in  32  byte address.
- Wr_Data  in  32  store data, right-justified.
- Rsp_Valid  out  1  one-cycle completion pulse.
- Rd_Data  out  32  extended load result, valid with Rsp_Valid.
- Rsp_Err  out  1  with Rsp_Valid: illegal width code or timeout.
- Bus_Req, Bus_We  out  1 each  bus request, write enable.
- Bus_Addr  out  32  word-aligned address (bits 1:0 = 0).
- Bus_WData  out  32  lane-aligned write data.
- Bus_BE  out  4  byte enables.
- Bus_Gnt  in  1  request accepted this cycle.
- Bus_RValid  in  1  read data returned.
- Bus_RData  in  32  read word.

Function
REQ-003 SHALL accept a request only when Req_Valid && Req_Ready; Addr, Wr_Data, Mem_Wr, dWidth_ctrl SHALL be registered on acceptance and inputs then ignored until Rsp_Valid.
REQ-004 SHALL use FSM states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP; Req_Ready = 1 only in IDLE.
REQ-005 Transitions: IDLE->REQ0 on accept; REQ0->WAIT0 on Bus_Gnt for loads, ->REQ1 (split) or RESP for stores; WAIT0->REQ1 (split) or RESP on Bus_RValid; REQ1->WAIT1 (load) or RESP (store) on Bus_Gnt; WAIT1->RESP on Bus_RValid; RESP->IDLE unconditionally.
REQ-006 Bus_Req SHALL be high in REQ0/REQ1 only, held with stable Bus_Addr/Bus_We/Bus_WData/Bus_BE until Bus_Gnt.
REQ-007 Split access SHALL occur when offset+size > 4 (H at offset 3; W at offsets 1-3): beat 0 at Addr&~3, beat 1 at (Addr&~3)+4, wrapping modulo 2^32.
REQ-008 Byte enables: beat 0 BE = ((1<<size)-1) << offset, truncated to 4 bits; beat 1 BE = bits shifted out; Bus_WData lanes SHALL carry Wr_Data rotated left by 8*offset on both beats.
REQ-009 Load data SHALL be assembled as {beat1,beat0} >> 8*offset, then sign-extended (B, H) or zero-extended (BU, HU) from size; W passes 32 bits.
REQ-010 Rsp_Valid SHALL be high exactly one cycle, in RESP; Rd_Data SHALL be 0 for stores and holds its value until the next RESP.
REQ-011 Minimum latency accept->Rsp_Valid: store 2 cycles, aligned load 3 cycles, with Bus_Gnt and Bus_RValid each one cycle after request.
REQ-012 Illegal width code (011, 11x, and 1xx for stores) SHALL skip bus activity: IDLE->RESP, Rsp_Err = 1.
REQ-013 A down-counter SHALL load TIMEOUT_CYC on entering each REQx/WAITx; reaching 0 SHALL force RESP with Rsp_Err = 1, dropping Bus_Req.
REQ-014 Bus_RValid outside WAIT0/WAIT1 and Bus_Gnt outside REQ0/REQ1 SHALL be ignored.
REQ-015 Bus_Gnt and Bus_RValid in the same cycle of REQx SHALL count as grant only; data is taken only in WAITx.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE, Req_Ready = 1, Rsp_Valid = 0, Rsp_Err = 0, Rd_Data = 0, Bus_Req = 0, Bus_We = 0, Bus_Addr = 0, Bus_WData = 0, Bus_BE = 0, timeout counter = 0.
REQ-017 Reset mid-transaction SHALL abandon it silently, with no Rsp_Valid after release.

Structure
REQ-018 Shared package SHALL hold the width-code enum (LB, LH, LW, LBU, LHU) and the FSM state enum.
REQ-019 Lane logic (BE, rotation, extension) SHALL be one combinational sub-module, lsu_align.

Verification
REQ-020 Store B, Addr 0x1003, Wr_Data 0xAB -> one beat, Bus_Addr 0x1000, BE 1000, WData 0xAB000000, Rsp_Valid 2 cycles after accept.
REQ-021 Load H, Addr 0x2003, RData beat0 0x80xxxxxx, beat1 0xxxxxxx01 -> two beats at 0x2000/0x2004, Rd_Data 0x00000180; same with HU -> 0x00000180; with byte 0x81 at beat1 and H -> 0xFFFF8180.
REQ-022 Load B 0x80 at offset 0 -> 0xFFFFFF80; BU -> 0x00000080.
REQ-023 Store W at 0xFFFFFFFE -> beats at 0xFFFFFFFC BE 1100 and 0x00000000 BE 0011.
REQ-024 Grant withheld TIMEOUT_CYC cycles -> Rsp_Valid with Rsp_Err = 1, Bus_Req low; width 011 -> error response after 1 cycle, no Bus_Req.
REQ-025 rst_n low during WAIT0 -> IDLE immediately, no Rsp_Valid; a stray Bus_RValid after reset is ignored.
